// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - UART two-byte command receiver; define UART_CMD_RX_PARITY_EN for 8E1 frames
module uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [3:0] cmd_a,
    output logic [3:0] cmd_b,
    output logic [2:0] cmd_opcode,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TMO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W   = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             phase_q, phase_d;
    logic [7:0]       byte0_q, byte0_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    logic             cmd_valid_q, cmd_valid_d;
    logic [3:0]       cmd_a_q, cmd_a_d;
    logic [3:0]       cmd_b_q, cmd_b_d;
    logic [2:0]       cmd_op_q, cmd_op_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
`ifdef UART_CMD_RX_PARITY_EN
    logic             parity_err_q, parity_err_d;
`endif

    logic rx_fall;
    logic byte_ok;
    logic byte_bad;
    logic abort;

    assign rx_fall = rx_prev_q & ~rx_s2_q;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // Frame FSM: bit timing, data shift, start/parity/stop checks
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
        parity_err_d = 1'b0;
`endif
        byte_ok     = 1'b0;
        byte_bad    = 1'b0;
        abort       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (ena && rx_fall) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_C) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s2_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST_C) begin
                    cnt_d   = '0;
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_CMD_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
`ifdef UART_CMD_RX_PARITY_EN
                if (cnt_q == LAST_C) begin
                    cnt_d = '0;
                    // Even parity: data plus parity bit must hold an even count of ones
                    if (^{shift_q, rx_s2_q}) begin
                        parity_err_d = 1'b1;
                        byte_bad     = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_STOP: begin
                if (cnt_q == LAST_C) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s2_q) begin
                        byte_ok = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        byte_bad    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Dropping enable mid-frame silently abandons the frame
        if (!ena && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            frame_err_d = 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
            parity_err_d = 1'b0;
`endif
            byte_ok     = 1'b0;
            byte_bad    = 1'b0;
            abort       = 1'b1;
        end
    end

    // Frame FSM state and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
`ifdef UART_CMD_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Byte pairing, inter-byte timeout and the command holding register
    always_comb begin
        phase_d     = phase_q;
        byte0_d     = byte0_q;
        tmo_d       = '0;
        cmd_valid_d = cmd_valid_q;
        cmd_a_d     = cmd_a_q;
        cmd_b_d     = cmd_b_q;
        cmd_op_d    = cmd_op_q;
        overrun_d   = 1'b0;
        if (cmd_valid_q && cmd_ready) begin
            cmd_valid_d = 1'b0;
        end
        if (abort || byte_bad) begin
            phase_d = 1'b0;
        end else if (byte_ok) begin
            if (!phase_q) begin
                byte0_d = shift_q;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                // A handshake in this same cycle frees the slot for the new command
                if (!cmd_valid_q || cmd_ready) begin
                    cmd_a_d     = byte0_q[7:4];
                    cmd_b_d     = byte0_q[3:0];
                    cmd_op_d    = shift_q[2:0];
                    cmd_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
        // Waiting for the opcode byte: give up if its start edge never arrives
        if (phase_q && (state_q == S_IDLE) && !(ena && rx_fall)) begin
            if (tmo_q == TMO_LAST) begin
                phase_d = 1'b0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // Command path registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= 1'b0;
            byte0_q     <= '0;
            tmo_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_a_q     <= '0;
            cmd_b_q     <= '0;
            cmd_op_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            byte0_q     <= byte0_d;
            tmo_q       <= tmo_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_a_q     <= cmd_a_d;
            cmd_b_q     <= cmd_b_d;
            cmd_op_q    <= cmd_op_d;
            overrun_q   <= overrun_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_a      = cmd_a_q;
    assign cmd_b      = cmd_b_q;
    assign cmd_opcode = cmd_op_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);
`ifdef UART_CMD_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - directed self-checking bench for uart_cmd_rx
module tb_uart_cmd_rx;

    localparam int CPB = 8;
    localparam int TOB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       rx;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_opcode;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;

    int n_frame = 0;
    int n_par   = 0;
    int n_ovr   = 0;
    int n_busy  = 0;
    int n_vcyc  = 0;
    int n_acc   = 0;
    logic [3:0] cap_a  = '0;
    logic [3:0] cap_b  = '0;
    logic [2:0] cap_op = '0;

    uart_cmd_rx #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .rx        (rx),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_opcode(cmd_opcode),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Event monitor on the falling edge, away from the DUT's active edge
    always @(negedge clk) begin
        if (frame_err === 1'b1) n_frame++;
        if (parity_err === 1'b1) n_par++;
        if (overrun === 1'b1) n_ovr++;
        if (busy === 1'b1) n_busy++;
        if (cmd_valid === 1'b1) n_vcyc++;
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            n_acc++;
            cap_a  = cmd_a;
            cap_b  = cmd_b;
            cap_op = cmd_opcode;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        step(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic pflip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_CMD_RX_PARITY_EN
        send_bit((^b) ^ pflip);
`endif
        send_bit(stop_bit);
        rx = 1'b1;
        step(4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        rst_n     = 1'b0;
        ena       = 1'b1;
        rx        = 1'b1;
        cmd_ready = 1'b0;
        step(3);
        check("rst_valid",   cmd_valid,  0);
        check("rst_a",       cmd_a,      0);
        check("rst_b",       cmd_b,      0);
        check("rst_op",      cmd_opcode, 0);
        check("rst_frame",   frame_err,  0);
        check("rst_parity",  parity_err, 0);
        check("rst_overrun", overrun,    0);
        check("rst_busy",    busy,       0);
        rst_n = 1'b1;
        step(4);

        // Basic command 0x35, 0x06 with consumer ready
        cmd_ready = 1'b1;
        send_byte(8'h35, 1'b1, 1'b0);
        send_byte(8'h06, 1'b1, 1'b0);
        step(2);
        check("basic_acc",   n_acc,  1);
        check("basic_a",     cap_a,  4'h3);
        check("basic_b",     cap_b,  4'h5);
        check("basic_op",    cap_op, 3'h6);
        check("basic_vcyc",  n_vcyc, 1);
        check("basic_vlow",  cmd_valid, 0);

        // Good byte, then bad stop bit resets phase; 0xA1, 0x02 forms the command
        send_byte(8'h44, 1'b1, 1'b0);
        send_byte(8'h35, 1'b0, 1'b0);
        check("frame_pulse", n_frame, 1);
        check("frame_noacc", n_acc,   1);
        send_byte(8'hA1, 1'b1, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0);
        step(2);
        check("frame_acc", n_acc,  2);
        check("frame_a",   cap_a,  4'hA);
        check("frame_b",   cap_b,  4'h1);
        check("frame_op",  cap_op, 3'h2);

        // False start: 3-cycle glitch
        b0 = n_busy;
        rx = 1'b0;
        step(3);
        rx = 1'b1;
        step(16);
        check("glitch_busy_seen", (n_busy > b0), 1);
        check("glitch_busy_low",  busy,    0);
        check("glitch_frame",     n_frame, 1);
        check("glitch_acc",       n_acc,   2);

        // Overrun: consumer stalled across two commands
        cmd_ready = 1'b0;
        send_byte(8'h12, 1'b1, 1'b0);
        send_byte(8'h01, 1'b1, 1'b0);
        check("hold_valid", cmd_valid,  1);
        check("hold_a",     cmd_a,      4'h1);
        check("hold_b",     cmd_b,      4'h2);
        check("hold_op",    cmd_opcode, 3'h1);
        send_byte(8'h34, 1'b1, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0);
        check("ovr_pulse", n_ovr,      1);
        check("ovr_valid", cmd_valid,  1);
        check("ovr_a",     cmd_a,      4'h1);
        check("ovr_b",     cmd_b,      4'h2);
        check("ovr_op",    cmd_opcode, 3'h1);
        cmd_ready = 1'b1;
        step(2);
        check("ovr_acc",   n_acc,  3);
        check("ovr_cap_a", cap_a,  4'h1);
        check("ovr_cap_op", cap_op, 3'h1);
        check("ovr_vlow",  cmd_valid, 0);

        // Enable dropped mid-frame on byte1: phase returns to 0
        send_byte(8'h21, 1'b1, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ena = 1'b0;
        step(2);
        ena = 1'b1;
        rx  = 1'b1;
        step(2 * CPB);
        check("ena_busy",  busy,    0);
        check("ena_frame", n_frame, 1);
        check("ena_acc",   n_acc,   3);
        send_byte(8'h43, 1'b1, 1'b0);
        send_byte(8'h01, 1'b1, 1'b0);
        step(2);
        check("ena_acc2", n_acc,  4);
        check("ena_a",    cap_a,  4'h4);
        check("ena_b",    cap_b,  4'h3);
        check("ena_op",   cap_op, 3'h1);

        // Inter-byte timeout discards 0x77
        send_byte(8'h77, 1'b1, 1'b0);
        step(40);
        send_byte(8'h56, 1'b1, 1'b0);
        step(2);
        check("tmo_noacc",  n_acc,     4);
        check("tmo_vlow",   cmd_valid, 0);
        send_byte(8'h03, 1'b1, 1'b0);
        step(2);
        check("tmo_acc", n_acc,  5);
        check("tmo_a",   cap_a,  4'h5);
        check("tmo_b",   cap_b,  4'h6);
        check("tmo_op",  cap_op, 3'h3);

        // Reset during DATA of byte1 with a command held
        cmd_ready = 1'b0;
        send_byte(8'h12, 1'b1, 1'b0);
        send_byte(8'h01, 1'b1, 1'b0);
        check("prerst_valid", cmd_valid, 1);
        send_byte(8'h9F, 1'b1, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        step(4);
        rst_n = 1'b0;
        rx    = 1'b1;
        step(2);
        check("midrst_valid", cmd_valid,  0);
        check("midrst_a",     cmd_a,      0);
        check("midrst_b",     cmd_b,      0);
        check("midrst_op",    cmd_opcode, 0);
        check("midrst_busy",  busy,       0);
        rst_n = 1'b1;
        step(CPB);
        cmd_ready = 1'b1;
        send_byte(8'h9F, 1'b1, 1'b0);
        send_byte(8'h07, 1'b1, 1'b0);
        step(2);
        check("postrst_acc", n_acc,  6);
        check("postrst_a",   cap_a,  4'h9);
        check("postrst_b",   cap_b,  4'hF);
        check("postrst_op",  cap_op, 3'h7);

`ifdef UART_CMD_RX_PARITY_EN
        send_byte(8'h9F, 1'b1, 1'b1);
        check("par_pulse", n_par, 1);
        send_byte(8'h07, 1'b1, 1'b0);
        step(2);
        check("par_noacc", n_acc,     6);
        check("par_vlow",  cmd_valid, 0);
`else
        check("par_none", n_par, 0);
`endif
        check("end_frame", n_frame, 1);
        check("end_ovr",   n_ovr,   1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200).
REQ-002 SHALL have parameter TIMEOUT_BITS, default 32, bit-times allowed between operand-byte stop and opcode-byte start.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ena  input  1  block enable.
REQ-006 SHALL have port rx  input  1  serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port cmd_ready  input  1  consumer accepts command.
REQ-008 SHALL have port cmd_valid  output  1  command available.
REQ-009 SHALL have port cmd_a  output  4  operand A.
REQ-010 SHALL have port cmd_b  output  4  operand B.
REQ-011 SHALL have port cmd_opcode  output  3  ALU opcode.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse, bad stop bit.
REQ-013 SHALL have port parity_err  output  1  one-cycle pulse, parity mismatch.
REQ-014 SHALL have port overrun  output  1  one-cycle pulse, command dropped.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE->START on synchronized falling edge of rx while ena=1.
REQ-019 START: at count CLKS_PER_BIT/2 (integer division), rx=0 -> DATA with counter cleared; rx=1 -> IDLE (false start), no flag.
REQ-020 DATA: sample one bit every CLKS_PER_BIT cycles at bit centre, 8 bits LSB first, then -> PARITY if enabled else STOP.
REQ-021 STOP: sample at bit centre; rx=1 -> byte accepted, -> IDLE; rx=0 -> frame_err pulse, byte discarded, -> IDLE.
REQ-022 Command = two bytes: byte0 gives cmd_a=byte0[7:4], cmd_b=byte0[3:0]; byte1 gives cmd_opcode=byte1[2:0], byte1[7:3] ignored.
REQ-023 SHALL track byte phase (0/1); a discarded byte (frame or parity error) resets phase to 0.
REQ-024 Phase 1 timeout: if no start edge within TIMEOUT_BITS*CLKS_PER_BIT cycles after byte0 acceptance, phase -> 0, byte0 discarded, no flag.
REQ-025 On byte1 acceptance with cmd_valid=0: load cmd_a/cmd_b/cmd_opcode, assert cmd_valid the following cycle.
REQ-026 On byte1 acceptance with cmd_valid=1 and cmd_ready=0 in that cycle: new command dropped, overrun pulse, held outputs unchanged.
REQ-027 Acceptance and cmd_ready handshake in the same cycle: old command consumed, new command loaded, cmd_valid stays 1, no overrun.
REQ-028 cmd_valid SHALL stay high, outputs stable, until the cycle where cmd_valid and cmd_ready are both 1; cleared next cycle.
REQ-029 Latency: cmd_valid rises 1 cycle after the stop-bit sample of byte1.
REQ-030 ena=0 mid-frame: abort to IDLE, phase -> 0, no flags; held command and cmd_valid unaffected.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, phase 0, all counters 0, synchronizer flops 1.
REQ-032 Reset values: cmd_valid=0, cmd_a=0, cmd_b=0, cmd_opcode=0, frame_err=0, parity_err=0, overrun=0, busy=0.
REQ-033 Reset mid-frame SHALL discard partial frame; first frame after release is received normally.

Configuration
REQ-034 Macro UART_CMD_RX_PARITY_EN defined: 9-bit frame, even parity bit after data sampled in PARITY; mismatch -> parity_err pulse, byte discarded, -> IDLE (stop bit not checked).
REQ-035 Macro undefined: PARITY state unreachable, frame 8N1, parity_err tied 0.

Verification (CLKS_PER_BIT=8, TIMEOUT_BITS=4)
REQ-036 Bytes 0x35 then 0x06, cmd_ready=1 -> cmd_valid one cycle, cmd_a=3, cmd_b=5, cmd_opcode=6.
REQ-037 Byte 0x35 with stop bit 0 -> frame_err pulse; then 0xA1, 0x02 -> cmd_a=0xA, cmd_b=1, cmd_opcode=2.
REQ-038 rx low 3 cycles then high -> no state change past START, busy returns 0, no flags.
REQ-039 cmd_ready=0, commands {0x12,0x01} then {0x34,0x02} -> overrun pulse once, outputs hold 1/2/1 until accepted.
REQ-040 Byte 0x77, 40 idle cycles, then 0x56, 0x03 -> command cmd_a=5, cmd_b=6 awaits byte; next byte completes, no spurious valid.
REQ-041 rst_n low during DATA of byte1 -> outputs at reset values; next {0x9F,0x07} -> cmd_a=9, cmd_b=0xF, cmd_opcode=7; with UART_CMD_RX_PARITY_EN, wrong parity on 0x9F -> parity_err pulse, no command.
